// File: rtl/i2c_xfer_sched_if.sv
// Bundle of requester-side and I2C-master-side signals for the transfer scheduler.
// master = the clients plus the I2C master (drive requests and status); slave = the scheduler.
interface i2c_xfer_sched_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]     req_vld;
  logic [NREQ*7-1:0]   req_addr;
  logic [NREQ-1:0]     req_rw;
  logic [NREQ*4-1:0]   req_len;
  logic [NREQ*128-1:0] req_wdata;
  logic [NREQ-1:0]     req_gnt;
  logic [NREQ-1:0]     req_done;
  logic                rsp_err;
  logic [127:0]        rsp_rdata;
  logic [15:0]         mst_ctrl;
  logic [127:0]        mst_wfifo;
  logic [127:0]        mst_rfifo;
  logic [7:0]          mst_status;

  modport master (
    output req_vld, req_addr, req_rw, req_len, req_wdata, mst_rfifo, mst_status,
    input  req_gnt, req_done, rsp_err, rsp_rdata, mst_ctrl, mst_wfifo
  );

  modport slave (
    input  req_vld, req_addr, req_rw, req_len, req_wdata, mst_rfifo, mst_status,
    output req_gnt, req_done, rsp_err, rsp_rdata, mst_ctrl, mst_wfifo
  );
endinterface

// File: rtl/i2c_xfer_sched.sv
// Round-robin scheduler sharing one I2C master among NREQ clients: grants, launches,
// tracks master busy with start/run timeouts, and returns read data with a done pulse.
module i2c_xfer_sched #(
  parameter int NREQ    = 4,
  parameter int STR_TMO = 64,
  parameter int RUN_TMO = 4096
) (
  input  logic                 clk,
  input  logic                 rstn,
  i2c_xfer_sched_if.slave      io_bus
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(RUN_TMO + 1);
  localparam logic [TW-1:0] STR_LAST = TW'(STR_TMO - 1);
  localparam logic [TW-1:0] RUN_LAST = TW'(RUN_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BSY,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_rr;
  logic [IW-1:0]   r_gidx;
  logic [TW-1:0]   r_timer;
  logic            r_busy_q;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic [127:0]    r_rdata;
  logic [15:0]     r_ctrl;
  logic [127:0]    r_wfifo;

  logic            w_busy;
  logic            w_busy_fall;
  logic            w_any;
  logic [IW-1:0]   w_lo;
  logic [IW-1:0]   w_hi;
  logic            w_hi_ok;
  logic [IW-1:0]   w_pick;
  logic [NREQ-1:0] w_pick_oh;
  logic [6:0]      w_sel_addr;
  logic            w_sel_rw;
  logic [3:0]      w_sel_len;
  logic [127:0]    w_sel_wdata;
  logic            w_fin;
  logic            w_fin_err;
  logic            w_unused_status;

  assign w_busy          = io_bus.mst_status[7];
  assign w_unused_status = ^io_bus.mst_status[6:0];
  assign w_busy_fall     = r_busy_q & ~w_busy;
  assign w_any           = |io_bus.req_vld;

  // Rotating priority: the lowest set index at/after r_rr wins, else the lowest overall.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_lo    = '0;
    w_hi    = '0;
    w_hi_ok = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (io_bus.req_vld[j]) begin
        w_lo = IW'(j);
        if (IW'(j) >= r_rr) begin
          w_hi    = IW'(j);
          w_hi_ok = 1'b1;
        end
      end
    end
    w_pick = w_hi_ok ? w_hi : w_lo;
  end

  always_comb begin
    w_pick_oh   = '0;
    w_sel_addr  = '0;
    w_sel_rw    = 1'b0;
    w_sel_len   = '0;
    w_sel_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (IW'(j) == w_pick) begin
        w_pick_oh[j] = 1'b1;
        w_sel_addr   = io_bus.req_addr[7*j +: 7];
        w_sel_rw     = io_bus.req_rw[j];
        w_sel_len    = io_bus.req_len[4*j +: 4];
        w_sel_wdata  = io_bus.req_wdata[128*j +: 128];
      end
    end
  end

  // Completion: busy never arrived, busy fell, or busy stayed up too long.
  always_comb begin
    w_fin     = 1'b0;
    w_fin_err = 1'b1;
    case (r_state)
      S_WAIT_BSY: w_fin = !w_busy && (r_timer >= STR_LAST);
      S_RUN: begin
        w_fin     = w_busy_fall || (r_timer >= RUN_LAST);
        w_fin_err = !w_busy_fall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_rr     <= '0;
      r_gidx   <= '0;
      r_timer  <= '0;
      r_busy_q <= 1'b0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_ctrl   <= '0;
      r_wfifo  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read sees the pre-edge value;
      // later assignments in this block intentionally override earlier defaults.
      r_busy_q <= w_busy;
      r_done   <= '0;
      if (r_timer != '1) r_timer <= r_timer + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_any && !w_busy) begin
            r_gidx  <= w_pick;
            r_gnt   <= w_pick_oh;
            r_ctrl  <= {w_sel_addr, w_sel_rw, 1'b1, 3'b000, w_sel_len};
            r_wfifo <= w_sel_wdata;
            r_timer <= '0;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_timer <= '0;
          r_state <= S_WAIT_BSY;
        end
        S_WAIT_BSY: begin
          if (w_busy) begin
            r_ctrl[7] <= 1'b0;
            r_timer   <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: ;
        S_DONE: begin
          r_gnt   <= '0;
          r_ctrl  <= '0;
          r_wfifo <= '0;
          r_rr    <= (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
          r_timer <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_fin) begin
        r_done    <= r_gnt;
        r_err     <= w_fin_err;
        if (r_ctrl[8]) r_rdata <= io_bus.mst_rfifo;
        r_ctrl[7] <= 1'b0;
        r_timer   <= '0;
        r_state   <= S_DONE;
      end
    end
  end

  assign io_bus.req_gnt   = r_gnt;
  assign io_bus.req_done  = r_done;
  assign io_bus.rsp_err   = r_err;
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.mst_ctrl  = r_ctrl;
  assign io_bus.mst_wfifo = r_wfifo;

endmodule

// File: tb/tb_i2c_xfer_sched.sv
// Bench for i2c_xfer_sched: directed scenarios plus randomized transfers, each checked
// against a cycle-count model derived from the arbitration and timeout rules.
module tb_i2c_xfer_sched;
  localparam int NREQ    = 4;
  localparam int STR_TMO = 64;
  localparam int RUN_TMO = 4096;
  localparam int NEVER   = 1000000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  i2c_xfer_sched_if #(.NREQ(NREQ)) bus ();

  i2c_xfer_sched #(.NREQ(NREQ), .STR_TMO(STR_TMO), .RUN_TMO(RUN_TMO)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0]      f_addr [NREQ];
  logic            f_rw   [NREQ];
  logic [3:0]      f_len  [NREQ];
  logic [127:0]    f_wd   [NREQ];
  int              rr_m      = 0;
  logic [127:0]    rdata_m   = '0;
  logic [15:0]     launch_ctrl;
  logic [NREQ-1:0] last_gnt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      f_addr[i] = 7'($urandom);
      f_rw[i]   = 1'($urandom);
      f_len[i]  = 4'($urandom);
      f_wd[i]   = rnd128();
    end
  endtask

  task automatic drive_req(input logic [NREQ-1:0] pat);
    bus.req_vld = pat;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[7*i +: 7]      = f_addr[i];
      bus.req_rw[i]               = f_rw[i];
      bus.req_len[4*i +: 4]       = f_len[i];
      bus.req_wdata[128*i +: 128] = f_wd[i];
    end
  endtask

  // First pending requester at or after the pointer, counting modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] pat, input int rr);
    for (int i = 0; i < NREQ; i++)
      if (pat[(rr + i) % NREQ]) return (rr + i) % NREQ;
    return 0;
  endfunction

  // Cycle 1 is LAUNCH (first negedge after the request is sampled). Busy driven at the
  // negedge of cycle k is seen on the following edge; a drop is seen one edge later.
  task automatic run_xfer(input logic [NREQ-1:0] pat, input int k_rise, input int k_fall,
                          input logic [127:0] rv, input bit drop, input string tag);
    int              g, r_edge, d_exp, done_at, done_cnt, trk_bad;
    bit              err_exp;
    logic [15:0]     ctrl_exp;
    logic [NREQ-1:0] oh;
    logic [127:0]    rd_exp;
    g        = pick(pat, rr_m);
    oh       = NREQ'(1) << g;
    ctrl_exp = {f_addr[g], f_rw[g], 1'b1, 3'b000, f_len[g]};
    if (k_rise + 1 > 2 + STR_TMO) begin
      r_edge  = NEVER;
      d_exp   = 2 + STR_TMO;
      err_exp = 1'b1;
    end else begin
      r_edge = (k_rise + 1 > 3) ? k_rise + 1 : 3;
      if (k_fall + 1 <= r_edge + RUN_TMO) begin
        d_exp   = k_fall + 1;
        err_exp = 1'b0;
      end else begin
        d_exp   = r_edge + RUN_TMO;
        err_exp = 1'b1;
      end
    end
    rd_exp   = f_rw[g] ? rv : rdata_m;
    done_at  = -1;
    done_cnt = 0;
    trk_bad  = 0;
    drive_req(pat);
    bus.mst_status = {1'b0, 7'($urandom)};
    bus.mst_rfifo  = rnd128();
    for (int c = 1; c <= d_exp + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        launch_ctrl = bus.mst_ctrl;
        last_gnt    = bus.req_gnt;
        check({tag, ".gnt"}, 128'(bus.req_gnt), 128'(oh));
        check({tag, ".ctrl"}, 128'(bus.mst_ctrl), 128'(ctrl_exp));
        check({tag, ".wfifo"}, bus.mst_wfifo, f_wd[g]);
      end
      if (c <= d_exp && bus.req_gnt !== oh) trk_bad++;
      if (c < d_exp) begin
        if ({bus.mst_ctrl[15:8], bus.mst_ctrl[6:0]} !== {ctrl_exp[15:8], ctrl_exp[6:0]}) trk_bad++;
        if (bus.mst_ctrl[7] !== (c < r_edge)) trk_bad++;
        if (bus.mst_wfifo !== f_wd[g]) trk_bad++;
      end
      if (bus.req_done !== '0) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == d_exp) begin
        check({tag, ".done"}, 128'(bus.req_done), 128'(oh));
        check({tag, ".err"}, 128'(bus.rsp_err), 128'(err_exp));
        check({tag, ".rdata"}, bus.rsp_rdata, rd_exp);
      end
      if (c == d_exp + 1) begin
        check({tag, ".gnt_off"}, 128'(bus.req_gnt), 128'(0));
        check({tag, ".ctrl_off"}, 128'(bus.mst_ctrl), 128'(0));
        check({tag, ".rdata_hold"}, bus.rsp_rdata, rd_exp);
      end
      if (c == 2 && drop) bus.req_vld[g] = 1'b0;
      bus.mst_status = {(c >= k_rise && c < k_fall && c <= d_exp), 7'($urandom)};
      bus.mst_rfifo  = (c == d_exp - 1) ? rv : rnd128();
    end
    check({tag, ".done_at"}, 128'(done_at), 128'(d_exp));
    check({tag, ".done_cnt"}, 128'(done_cnt), 128'(1));
    check({tag, ".track"}, 128'(trk_bad), 128'(0));
    rdata_m = rd_exp;
    rr_m    = (g + 1) % NREQ;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int fb_bad;
    int kr;
    bus.req_vld    = '0;
    bus.req_addr   = '0;
    bus.req_rw     = '0;
    bus.req_len    = '0;
    bus.req_wdata  = '0;
    bus.mst_rfifo  = '0;
    bus.mst_status = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst.gnt", 128'(bus.req_gnt), 128'(0));
    check("rst.done", 128'(bus.req_done), 128'(0));
    check("rst.err", 128'(bus.rsp_err), 128'(0));
    check("rst.rdata", bus.rsp_rdata, 128'(0));
    check("rst.ctrl", 128'(bus.mst_ctrl), 128'(0));
    check("rst.wfifo", bus.mst_wfifo, 128'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Round robin with every requester held
    rand_fields();
    for (int i = 0; i < 5; i++) begin
      run_xfer(4'b1111, 2 + i, 10 + 3 * i, rnd128(), 1'b0, "rr");
      check("rr.order", 128'(last_gnt), 128'(4'b0001 << order[i]));
    end

    // Single write to 0x50, three-byte length
    rand_fields();
    f_addr[0] = 7'h50;
    f_rw[0]   = 1'b0;
    f_len[0]  = 4'd3;
    run_xfer(4'b0001, 4, 204, rnd128(), 1'b0, "wr");
    check("wr.ctrl_lit", 128'(launch_ctrl), 128'(16'hA083));

    // Read returns master data captured at the busy fall
    rand_fields();
    f_rw[1] = 1'b1;
    run_xfer(4'b0010, 3, 30, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D, 1'b1, "rd");
    check("rd.lit", bus.rsp_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D);

    // Start timeout: busy never rises
    rand_fields();
    run_xfer(4'b0100, NEVER, NEVER, rnd128(), 1'b0, "stmo");

    // Run timeout: busy stuck high
    rand_fields();
    run_xfer(4'b1000, 3, NEVER, rnd128(), 1'b0, "rtmo");

    // Foreign traffic holds off the grant
    rand_fields();
    drive_req(4'b0100);
    bus.mst_status = 8'h80;
    fb_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_gnt !== '0) fb_bad++;
    end
    check("fbusy.nognt", 128'(fb_bad), 128'(0));
    run_xfer(4'b0100, 5, 25, rnd128(), 1'b0, "fbusy");

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      rand_fields();
      kr = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(2, 12));
      run_xfer(NREQ'($urandom_range(1, 15)), kr, kr + int'($urandom_range(1, 40)),
               rnd128(), 1'($urandom), "rand");
    end

    // Reset in the middle of a running transfer
    rand_fields();
    run_xfer(4'b0010, 3, 10, rnd128(), 1'b0, "pre_rst");
    rand_fields();
    drive_req(4'b1000);
    bus.mst_status = 8'h00;
    @(negedge clk);
    check("mrst.gnt_before", 128'(bus.req_gnt), 128'(4'b1000));
    bus.mst_status = 8'h80;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("mrst.gnt", 128'(bus.req_gnt), 128'(0));
    check("mrst.done", 128'(bus.req_done), 128'(0));
    check("mrst.ctrl", 128'(bus.mst_ctrl), 128'(0));
    @(negedge clk);
    rstn           = 1'b1;
    bus.mst_status = 8'h00;
    rr_m           = 0;
    rdata_m        = '0;
    rand_fields();
    run_xfer(4'b1011, 4, 12, rnd128(), 1'b0, "post_rst");
    check("post_rst.rr0", 128'(last_gnt), 128'(4'b0001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
